// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// WIDTH   : operand / quotient / remainder width
// CNT_W   : width of the iteration counter (one iteration per quotient bit)
// state_t : divider control states
package divider_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_r : partial remainder (WIDTH+1 bits)
//   i_q : quotient/dividend shift register; its MSB is the next dividend bit
//   i_b : divisor
//   o_r : next partial remainder
//   o_q : next quotient/dividend shift register (new quotient bit in the LSB)
module div_step #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_s;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic             w_unused_r_msb;

    // Shifted remainder with the next dividend bit appended.
    assign w_s = {i_r[WIDTH-1:0], i_q[WIDTH-1]};

    // One extra bit so the top bit of the difference is the borrow.
    assign w_diff   = {1'b0, w_s} - {2'b00, i_b};
    assign w_borrow = w_diff[WIDTH+1];

    // Borrow means the trial subtraction went negative: restore (keep s).
    assign o_r = w_borrow ? w_s : w_diff[WIDTH:0];
    assign o_q = {i_q[WIDTH-2:0], ~w_borrow};

    // The partial remainder is always below the divisor entering a step,
    // so its top bit never contributes to the shifted value.
    assign w_unused_r_msb = i_r[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit resolved per clock.
// Latency: WIDTH cycles after the start edge; divide-by-zero result after one cycle.
// Backpressure: result held in HOLD while Run stays low; Run must be released before the next start.
//
// Ports:
//   Clk    : system clock
//   Reset  : asynchronous, active-low; clears all state
//   Load_B : active-low; loads the divisor from Din while idle
//   Run    : active-low; starts a division with Din as dividend while idle
//   Din    : switch input (divisor on Load_B, dividend on start)
//   Qval   : quotient register
//   Rval   : remainder register (low WIDTH bits of the internal remainder)
//   Bval   : divisor register
//   Done   : high while the result is held
//   Div0   : high with the held result when the divisor was zero
module restoring_divider #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_B,
    input  logic             Run,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic [WIDTH-1:0] Bval,
    output logic             Done,
    output logic             Div0
);

    import divider_pkg::*;

    // Counter wide enough to index WIDTH iterations (CNT_W for the default width).
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_div0;

    logic [WIDTH:0]   w_r_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_b_zero;
    logic             w_done;

    assign w_b_zero = (r_b == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_b (r_b),
        .o_r (w_r_nxt),
        .o_q (w_q_nxt)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // A divisor load takes priority over a start on the same edge.
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (Load_B && !Run) begin
                    w_state_nxt = w_b_zero ? HOLD : COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Leave only on release so one press gives one division.
                if (Run) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: Moore outputs
    // ---------------------------------------------------------------
    always_comb begin
        w_done = 1'b0;
        if (r_state == HOLD) begin
            w_done = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // Q doubles as the dividend shift register during COMPUTE.
    // Results stay untouched through HOLD and IDLE until the next start.
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_q    <= '0;
            r_r    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!Load_B) begin
                        r_b <= Din;
                    end else if (!Run) begin
                        if (w_b_zero) begin
                            // Saturated quotient, dividend passed through as remainder.
                            r_q    <= '1;
                            r_r    <= {1'b0, Din};
                            r_div0 <= 1'b1;
                        end else begin
                            r_q    <= Din;
                            r_r    <= '0;
                            r_cnt  <= '0;
                            r_div0 <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign Qval = r_q;
    assign Rval = r_r[WIDTH-1:0];
    assign Bval = r_b;
    assign Done = w_done;
    assign Div0 = r_div0;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed scenarios plus randomized operands
// compared against a plain-arithmetic reference (a / b, a % b, divide-by-zero saturation).
module tb_restoring_divider;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         Load_B;
    logic         Run;
    logic [W-1:0] Din;
    logic [W-1:0] Qval;
    logic [W-1:0] Rval;
    logic [W-1:0] Bval;
    logic         Done;
    logic         Div0;

    int n_vec = 0;
    int n_err = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load_B (Load_B),
        .Run    (Run),
        .Din    (Din),
        .Qval   (Qval),
        .Rval   (Rval),
        .Bval   (Bval),
        .Done   (Done),
        .Div0   (Div0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: unsigned division; divide by zero saturates quotient and
    // returns the dividend as remainder.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // All stimulus tasks are entered just after a falling edge.
    task automatic load_b(input logic [W-1:0] b);
        Load_B = 1'b0;
        Din    = b;
        @(negedge Clk);
        Load_B = 1'b1;
        Din    = W'($urandom);
    endtask

    // Waits for Done; edges = rising edges after the start edge (-1 on timeout).
    // Din (and optionally Load_B) is scrambled meanwhile; neither may matter.
    task automatic wait_done(input int budget, input bit scramble_load, output int edges);
        edges = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                edges = i;
                break;
            end
            Din = W'($urandom);
            if (scramble_load) Load_B = 1'($urandom);
        end
        Load_B = 1'b1;
    endtask

    task automatic start_div(input logic [W-1:0] a, input bit scramble_load, output int edges);
        Din = a;
        Run = 1'b0;
        wait_done(20, scramble_load, edges);
    endtask

    task automatic release_run();
        Run = 1'b1;
        Din = W'($urandom);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Load_B = 1'b1; Run = 1'b1; Din = '0;
        #1 Reset = 1'b0;
        #3;
        n_vec++; if (Qval !== 0) begin n_err++; $display("FAIL reset_q: got %0h want 0", Qval); end
        n_vec++; if (Rval !== 0) begin n_err++; $display("FAIL reset_r: got %0h want 0", Rval); end
        n_vec++; if (Bval !== 0) begin n_err++; $display("FAIL reset_b: got %0h want 0", Bval); end
        n_vec++; if (Done !== 0) begin n_err++; $display("FAIL reset_done: got %0b want 0", Done); end
        n_vec++; if (Div0 !== 0) begin n_err++; $display("FAIL reset_div0: got %0b want 0", Div0); end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        int e;
        load_b(8'd2);
        n_vec++; if (Bval !== 8'd2) begin n_err++; $display("FAIL basic_bval: got %0h want 2", Bval); end
        start_div(8'd7, 1'b0, e);
        n_vec++; if (e !== W) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", e, W); end
        n_vec++; if (Qval !== 8'd3) begin n_err++; $display("FAIL basic_q: got %0h want 3", Qval); end
        n_vec++; if (Rval !== 8'd1) begin n_err++; $display("FAIL basic_r: got %0h want 1", Rval); end
        n_vec++; if (Div0 !== 1'b0) begin n_err++; $display("FAIL basic_div0: got %0b want 0", Div0); end
        release_run();
        n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL basic_done_release: got %0b want 0", Done); end
        n_vec++; if (Qval !== 8'd3 || Rval !== 8'd1) begin
            n_err++; $display("FAIL basic_held: got q=%0h r=%0h want q=3 r=1", Qval, Rval);
        end
    endtask

    task automatic test_max_divisor();
        int e;
        load_b(8'hFF);
        start_div(8'hFF, 1'b0, e);
        n_vec++; if (Qval !== 8'd1 || Rval !== 8'd0 || e !== W) begin
            n_err++; $display("FAIL ff_ff: got q=%0h r=%0h lat=%0d want q=1 r=0 lat=%0d", Qval, Rval, e, W);
        end
        release_run();
        start_div(8'd3, 1'b0, e);
        n_vec++; if (Qval !== 8'd0 || Rval !== 8'd3) begin
            n_err++; $display("FAIL ff_3: got q=%0h r=%0h want q=0 r=3", Qval, Rval);
        end
        release_run();
    endtask

    task automatic test_hold();
        int e;
        int bad;
        load_b(8'd3);
        start_div(8'hFF, 1'b0, e);
        n_vec++; if (Qval !== 8'h55 || Rval !== 8'd0) begin
            n_err++; $display("FAIL hold_result: got q=%0h r=%0h want q=55 r=0", Qval, Rval);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            Din = W'($urandom);
            @(negedge Clk);
            if (Done !== 1'b1 || Qval !== 8'h55 || Rval !== 8'd0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        release_run();
        n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL hold_release: got done=%0b want 0", Done); end
    endtask

    task automatic test_div0();
        int e;
        load_b(8'd0);
        start_div(8'h2A, 1'b0, e);
        n_vec++; if (e !== 0) begin n_err++; $display("FAIL div0_latency: got %0d want 0", e); end
        n_vec++; if (Div0 !== 1'b1 || Qval !== 8'hFF || Rval !== 8'h2A) begin
            n_err++; $display("FAIL div0_result: got div0=%0b q=%0h r=%0h want 1 ff 2a", Div0, Qval, Rval);
        end
        release_run();
        n_vec++; if (Div0 !== 1'b1 || Done !== 1'b0) begin
            n_err++; $display("FAIL div0_idle: got div0=%0b done=%0b want 1 0", Div0, Done);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        logic [W-1:0] a;
        load_b(8'd9);
        Din = 8'hC8;
        Run = 1'b0;
        repeat (5) @(negedge Clk);
        #2;
        Reset = 1'b0;
        Run   = 1'b1;
        #1;
        n_vec++; if (Qval !== 0 || Rval !== 0 || Bval !== 0 || Done !== 0 || Div0 !== 0) begin
            n_err++; $display("FAIL reset_mid: got q=%0h r=%0h b=%0h done=%0b div0=%0b want all 0",
                              Qval, Rval, Bval, Done, Div0);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        a = W'($urandom);
        start_div(a, 1'b0, e);
        n_vec++; if (e !== 0 || Div0 !== 1'b1 || Qval !== 8'hFF || Rval !== a) begin
            n_err++; $display("FAIL reset_restart: got lat=%0d div0=%0b q=%0h r=%0h want 0 1 ff %0h",
                              e, Div0, Qval, Rval, a);
        end
        release_run();
    endtask

    task automatic test_load_and_run();
        int e;
        Load_B = 1'b0;
        Run    = 1'b0;
        Din    = 8'd5;
        @(negedge Clk);
        n_vec++; if (Bval !== 8'd5 || Done !== 1'b0) begin
            n_err++; $display("FAIL load_wins: got b=%0h done=%0b want 5 0", Bval, Done);
        end
        Load_B = 1'b1;
        wait_done(20, 1'b0, e);
        n_vec++; if (e !== W || Qval !== 8'd1 || Rval !== 8'd0) begin
            n_err++; $display("FAIL load_then_run: got lat=%0d q=%0h r=%0h want %0d 1 0", e, Qval, Rval, W);
        end
        release_run();
    endtask

    task automatic test_random();
        int e;
        logic [W-1:0] a, b, eq, er;
        logic ez;
        for (int n = 0; n < 24; n++) begin
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (n == 1) b = 8'd1;
            a = W'($urandom);
            model(a, b, eq, er, ez);
            load_b(b);
            start_div(a, 1'b1, e);
            n_vec++; if (e !== (ez ? 0 : W)) begin
                n_err++; $display("FAIL rand_latency: a=%0h b=%0h got %0d want %0d", a, b, e, ez ? 0 : W);
            end
            n_vec++; if (Qval !== eq || Rval !== er || Div0 !== ez) begin
                n_err++; $display("FAIL rand_result: a=%0h b=%0h got q=%0h r=%0h z=%0b want q=%0h r=%0h z=%0b",
                                  a, b, Qval, Rval, Div0, eq, er, ez);
            end
            n_vec++; if (Bval !== b) begin
                n_err++; $display("FAIL rand_bval: got %0h want %0h", Bval, b);
            end
            release_run();
            n_vec++; if (Done !== 1'b0 || Qval !== eq || Rval !== er) begin
                n_err++; $display("FAIL rand_idle_hold: got done=%0b q=%0h r=%0h want 0 %0h %0h",
                                  Done, Qval, Rval, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_divisor();
        test_hold();
        test_div0();
        test_reset_mid();
        test_load_and_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

- Sequential 8-bit unsigned restoring divider; the inverse-operation companion to the team's shift-add `multiplier_top_level`.
- Same board-level usage model as the multiplier:
  - a divisor is loaded from the switches (`Din`);
  - a dividend is presented on `Din` and `Run` is pressed;
  - one quotient bit is resolved per clock;
  - the result is held until `Run` is released.
- Sits beside the multiplier under the same top-level and feeds the same hex display drivers.

## Interface
Parameters:
- `WIDTH`, 8, operand/quotient/remainder width

Ports:
- `Clk`  in  1  system clock (50 MHz)
- `Reset`  in  1  asynchronous, active-low; clears all state
- `Load_B`  in  1  active-low, synchronous; loads divisor register from `Din`
- `Run`  in  1  active-low, synchronous; starts a division
- `Din`  in  WIDTH  switch input; divisor on `Load_B`, dividend on start
- `Qval`  out  WIDTH  quotient register
- `Rval`  out  WIDTH  remainder register
- `Bval`  out  WIDTH  divisor register
- `Done`  out  1  high while the result is held (`HOLD` state)
- `Div0`  out  1  high in `HOLD` when the divisor was zero

## Operation
- Registers: `Q[7:0]`, `R[8:0]` (internal 9-bit; `Rval = R[7:0]`), `B[7:0]`, `cnt[2:0]`, FSM state.
- States: `IDLE`, `COMPUTE`, `HOLD`.
- `IDLE`:
  - `Load_B`=0 → `B <= Din`; stay `IDLE`.
  - Else if `Run`=0 and `B`≠0 → `R <= 0`, `Q <= Din`, `cnt <= 0`, `Div0 <= 0`; go to `COMPUTE`.
  - Else if `Run`=0 and `B`=0 → `Q <= 8'hFF`, `R <= {1'b0,Din}`, `Div0 <= 1`; go to `HOLD`.
- `COMPUTE`, each cycle:
  - `s = {R[7:0], Q[7]}`; `t = s − {1'b0,B}` (9-bit).
  - If `t` non-negative (no borrow): `R <= t`, `Q <= {Q[6:0],1}`.
  - Else: `R <= s`, `Q <= {Q[6:0],0}`.
  - `cnt <= cnt+1`; when `cnt`=7 go to `HOLD`.
- `HOLD`: `Done`=1; stay while `Run`=0; `Run`=1 → `IDLE`. This gives exactly one division per press.
- `Load_B` is ignored outside `IDLE`. `Din` changes during `COMPUTE` have no effect.
- `Qval`/`Rval`/`Div0` keep the last result through `IDLE` until the next start.
- Unsigned only; quotient always fits in 8 bits (divisor ≥1).

## Timing
- Reset (async, any state, including mid-`COMPUTE`):
  - state = `IDLE`;
  - `Q`, `R`, `B`, `cnt` = 0;
  - `Done` = 0, `Div0` = 0.
- Edge k samples `Run`=0 in `IDLE` (B≠0):
  - edges k+1..k+8 perform iterations 0..7;
  - state `HOLD` after edge k+8;
  - `Done` rises after edge k+8;
  - latency 8 cycles after the start edge.
- Divide by zero: `HOLD`, `Done`, `Div0` and all outputs valid after edge k (1 cycle).
- `Load_B` and `Run` both low in `IDLE`:
  - the load wins that edge;
  - the start occurs on the next edge if `Run` is still low, using the new `B`.
- `Done` is a Moore output: `Done = (state==HOLD)`.
- `Run` low in `IDLE` immediately after `HOLD` requires `Run` to have gone high first. No re-trigger without release.

## Structure
- Package `divider_pkg`:
  - `WIDTH` constant;
  - `state_t` enum {`IDLE`, `COMPUTE`, `HOLD`};
  - `CNT_W` = $clog2(`WIDTH`).
- One sub-module, `div_step`, combinational:
  - inputs `R`, `Q`, `B`;
  - outputs next `R`, next `Q`.
  - Reusable for a later pipelined variant.
- Top `restoring_divider` holds the FSM, counter and registers.
- Hex display driving is left to the existing top-level `HexDriver` instances.

## Test plan
- Reset low, then high; `Load_B` with `Din`=2; `Run` with `Din`=7 → after 8 cycles `Qval`=3, `Rval`=1, `Done`=1, `Div0`=0.
- `B`=8'hFF, dividend 8'hFF → `Qval`=1, `Rval`=0. `B`=8'hFF, dividend 3 → `Qval`=0, `Rval`=3.
- `B`=3, dividend 8'hFF → `Qval`=8'h55, `Rval`=0. `Run` held low 50 cycles → exactly one division, `Done` stays 1 until release.
- `B`=0, dividend 8'h2A → one cycle later `Div0`=1, `Done`=1, `Qval`=8'hFF, `Rval`=8'h2A.
- Assert `Reset` low at iteration 4 → all outputs 0 immediately (before the next edge). Next `Run` restarts cleanly with `B`=0 → `Div0` path.
- `Load_B` and `Run` low on the same edge with `Din`=5 → `Bval`=5 first. Then a division proceeds with divisor 5 on dividend 5 → `Qval`=1, `Rval`=0.
